// File: rtl/regfile_sb.sv
// Multi-port register file with two write ports, optional write-to-read bypass
// and a per-register scoreboard of pending producers for hazard detection.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [NREAD*ADDR_W-1:0]  ra,
  output logic [NREAD*DATA_W-1:0]  rd,
  output logic [NREAD-1:0]         busy,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  if (NREAD < 1 || NREAD > 4) begin : g_bad_nread
    $error("regfile_sb: NREAD must be in 1..4");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  sb;
  logic [DEPTH-1:0]  sb_next;
  logic [ADDR_W:0]   pend_next;

  // NOTE: the register array is reset explicitly because the pipeline relies on
  // every architectural register reading 0 after reset, not only r0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      // Port 1 is assigned last so it wins a same-address collision.
      if (we0 && wa0 != '0) mem[wa0] <= wd0;
      if (we1 && wa1 != '0) mem[wa1] <= wd1;
    end
  end

  // NOTE: every combinational output gets a default before any condition so no
  // latch is inferred.
  always_comb begin
    sb_next = sb;
    if (we0) sb_next[wa0] = 1'b0;
    if (we1) sb_next[wa1] = 1'b0;
    // A newly issued producer supersedes the one completing on this edge.
    if (sb_set) sb_next[sb_addr] = 1'b1;
    sb_next[0] = 1'b0;
    pend_next = '0;
    for (int r = 1; r < DEPTH; r++) begin
      pend_next = pend_next + {{ADDR_W{1'b0}}, sb_next[r]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb       <= '0;
      pend_cnt <= '0;
    end else begin
      sb       <= sb_next;
      pend_cnt <= pend_next;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit0;
    logic              hit1;
    logic [DATA_W-1:0] rd_i;
    logic              busy_i;

    assign addr = ra[i*ADDR_W +: ADDR_W];
    assign hit0 = (BYPASS != 0) && we0 && (wa0 == addr);
    assign hit1 = (BYPASS != 0) && we1 && (wa1 == addr);

    always_comb begin
      rd_i = '0;
      if (rst_n && addr != '0) begin
        if (hit1)      rd_i = wd1;
        else if (hit0) rd_i = wd0;
        else           rd_i = mem[addr];
      end
    end

    // A write landing this cycle resolves the hazard when it is forwarded.
    assign busy_i = rst_n && (addr != '0) && sb[addr] && !(hit0 || hit1);

    assign rd[i*DATA_W +: DATA_W] = rd_i;
    assign busy[i]                = busy_i;
  end

endmodule
